// File: rtl/hs_2_axi_if.sv
// Signal bundle between a handshake requester, the hs_2_axi bridge and an AXI4-Lite slave.
// The slave modport is the bridge's view; master is the environment's view.
interface hs_2_axi_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  hs_read;
  logic                  hs_write;
  logic [ADDR_WIDTH-1:0] hs_addr;
  logic [DATA_WIDTH-1:0] hs_wdata;
  logic [STRB_WIDTH-1:0] byte_select;
  logic                  hs_ready;
  logic [DATA_WIDTH-1:0] hs_rdata;
  logic                  hs_err;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport slave (
    input  hs_read, hs_write, hs_addr, hs_wdata, byte_select,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
    output hs_ready, hs_rdata, hs_err,
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready
  );

  modport master (
    output hs_read, hs_write, hs_addr, hs_wdata, byte_select,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
    input  hs_ready, hs_rdata, hs_err,
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready
  );
endinterface

// File: rtl/hs_2_axi.sv
// Handshake-bus to AXI4-Lite master bridge, one outstanding access at a time.
// Every output is a register; request fields are latched when leaving idle.
module hs_2_axi #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic         clk,
  input logic         rst,
  hs_2_axi_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdAddr = 3'd1,
    StRdData = 3'd2,
    StWr     = 3'd3,
    StWrResp = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  ready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic aw_fire;
  logic w_fire;

  assign aw_fire = awvalid_q & bus.awready;
  assign w_fire  = wvalid_q & bus.wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.hs_read || bus.hs_write) begin
            addr_q  <= bus.hs_addr;
            wdata_q <= bus.hs_wdata;
            strb_q  <= bus.byte_select;
          end
          // Read has priority when both requests are raised together.
          if (bus.hs_read) begin
            arvalid_q <= 1'b1;
            state_q   <= StRdAddr;
          end else if (bus.hs_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= StWr;
          end
        end
        StRdAddr: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= bus.rdata;
            err_q    <= (bus.rresp != 2'b00);
            ready_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StWr: begin
          // Address and data channels complete independently, in either order.
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
            bready_q <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            err_q    <= (bus.bresp != 2'b00);
            ready_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          ready_q   <= 1'b0;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign bus.hs_ready = ready_q;
  assign bus.hs_rdata = rdata_q;
  assign bus.hs_err   = err_q;
  assign bus.arvalid  = arvalid_q;
  assign bus.araddr   = addr_q;
  assign bus.rready   = rready_q;
  assign bus.awvalid  = awvalid_q;
  assign bus.awaddr   = addr_q;
  assign bus.wvalid   = wvalid_q;
  assign bus.wdata    = wdata_q;
  assign bus.wstrb    = strb_q;
  assign bus.bready   = bready_q;

endmodule
